// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame command encodings, master FSM states and a
// small constant helper. Imported by spi_master and available to the slave.
// No ports; compile before any file that imports it.
package spi_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    RECV = 3'd4,
    END  = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master: sends {cmd,data_in} MSB first on MOSI, and on a read-data frame
//   waits RD_GAP cycles then captures ADDR_SIZE bits from MISO into rd_data.
// Latency: done ADDR_SIZE+3 edges after accept (write/read-addr), or
//   2*ADDR_SIZE+RD_GAP+3 edges after accept (read-data).
// Backpressure: start is taken only in IDLE or in the END cycle; while busy it
//   is ignored, the requester must hold it.
// Ports: clk, rst_n, start, cmd[1:0], data_in -> busy, done, rd_data, rd_valid,
//   SS_n, MOSI; MISO in.
// Option: SPI_MASTER_SEQ_CHECK_EN adds output err and rejects cmd 01 not
//   preceded by 00 and cmd 11 not preceded by 10.
module spi_master
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int RD_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           cmd,
  input  logic [ADDR_SIZE-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 SS_n,
  output logic                 MOSI,
`ifdef SPI_MASTER_SEQ_CHECK_EN
  input  logic                 MISO,
  output logic                 err
`else
  input  logic                 MISO
`endif
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(max_int(FRAME_W, RD_GAP) + 1);

  // Counter runs load..0, so each load is the state length minus one.
  localparam logic [CNT_W-1:0] SEND_LOAD = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((RD_GAP > 0) ? RD_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] RECV_LOAD = CNT_W'(ADDR_SIZE - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   tx_q;
  logic [ADDR_SIZE-1:0] rx_q, rx_next, rd_data_q;
  logic [1:0]           frame_cmd_q;
  logic                 can_accept, seq_ok, accept, cnt_zero;

  // END also accepts, so back-to-back frames see SS_n high for one cycle only.
  assign can_accept = start && ((state_q == IDLE) || (state_q == END));
  assign accept     = can_accept && seq_ok;
  assign cnt_zero   = (cnt_q == '0);
  assign rx_next    = (rx_q << 1) | ADDR_SIZE'(MISO);

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic [1:0] last_cmd_q;
  logic       err_q;

  assign seq_ok = !(((cmd == CMD_WR_DATA) && (last_cmd_q != CMD_WR_ADDR)) ||
                    ((cmd == CMD_RD_DATA) && (last_cmd_q != CMD_RD_ADDR)));

  // Tracker starts as "read-data" so neither data command is legal until its
  // address command has been sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cmd_q <= CMD_RD_DATA;
      err_q      <= 1'b0;
    end else begin
      err_q <= can_accept && !seq_ok;
      if (accept) last_cmd_q <= cmd;
    end
  end

  assign err = err_q;
`else
  assign seq_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) state_d = SEL;
      SEL: begin
        state_d = SEND;
        cnt_d   = SEND_LOAD;
      end
      SEND: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (frame_cmd_q != CMD_RD_DATA) begin
          state_d = END;
        end else if (RD_GAP == 0) begin
          state_d = RECV;
          cnt_d   = RECV_LOAD;
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RECV;
          cnt_d   = RECV_LOAD;
        end
      end
      RECV: begin
        if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
        else           state_d = END;
      end
      END:     state_d = accept ? SEL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // tx_q is not shifted in SEL: its MSB (cmd[1]) is driven there and again as
  // the first SEND bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q        <= '0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      frame_cmd_q <= '0;
    end else begin
      if (accept) begin
        tx_q        <= {cmd, data_in};
        frame_cmd_q <= cmd;
      end else if (state_q == SEND) begin
        tx_q <= tx_q << 1;
      end
      if (state_q == RECV) begin
        rx_q <= rx_next;
        // Load on the last sample so rd_data is already valid during END.
        if (cnt_zero) rd_data_q <= rx_next;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == END);
  assign rd_valid = (state_q == END) && (frame_cmd_q == CMD_RD_DATA);
  assign rd_data  = rd_data_q;
  assign SS_n     = !((state_q == SEL) || (state_q == SEND) ||
                      (state_q == GAP) || (state_q == RECV));
  assign MOSI     = ((state_q == SEL) || (state_q == SEND)) ? tx_q[FRAME_W-1] : 1'b0;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, the width of the address/data payload.
REQ-002 SHALL have parameter RD_GAP, default 2, the idle clk cycles between the last command bit and the first MISO sample.
REQ-003 SHALL have port clk  input  1  system clock; it is also the serial bit clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  transaction request, sampled when busy=0.
REQ-006 SHALL have port cmd  input  2  frame type: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-007 SHALL have port data_in  input  ADDR_SIZE  payload sent after cmd.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse at the end of a frame.
REQ-010 SHALL have port rd_data  output  ADDR_SIZE  byte captured from MISO on a cmd=11 frame.
REQ-011 SHALL have port rd_valid  output  1  single-cycle pulse, rd_data valid.
REQ-012 SHALL have port SS_n  output  1  slave select, active low.
REQ-013 SHALL have port MOSI  output  1  serial data to the slave.
REQ-014 SHALL have port MISO  input  1  serial data from the slave.

Function
REQ-015 SHALL implement the states IDLE, SEL, SEND, GAP, RECV and END.
REQ-016 SHALL, in IDLE with start=1, latch {cmd,data_in} into a (ADDR_SIZE+2)-bit shift register and go to SEL; start while busy=1 is ignored.
REQ-017 SHALL, in SEL (1 cycle), drive SS_n=0 and MOSI=cmd[1] as the slave's write/read select bit.
REQ-018 SHALL, in SEND (ADDR_SIZE+2 cycles), shift the register out MSB first on MOSI, one bit per clk, with SS_n=0.
REQ-019 SHALL go from SEND to END for cmd 00/01/10, and to GAP for cmd 11.
REQ-020 SHALL hold SS_n=0 and MOSI=0 for RD_GAP cycles in GAP, then go to RECV.
REQ-021 SHALL, in RECV (ADDR_SIZE cycles), sample MISO on each rising clk, MSB first, into the receive register.
REQ-022 SHALL, in END (1 cycle), drive SS_n=1 and pulse done; after a cmd=11 frame it also loads rd_data and pulses rd_valid in the same cycle; the next state is IDLE.
REQ-023 SHALL give these latencies, with start accepted at edge N: a write or read-address frame has done=1 in cycle N+ADDR_SIZE+4, and a read-data frame has done=1 in cycle N+2*ADDR_SIZE+RD_GAP+4.
REQ-024 SHALL assert busy from the cycle after start is accepted through END, and deassert it in IDLE.
REQ-025 SHALL accept a start asserted in the cycle done is high on the next edge; back-to-back frames have SS_n high for at least 1 cycle between them.
REQ-026 SHALL use one down-counter for SEND, GAP and RECV, loaded on each state entry; the counter is wide enough for max(ADDR_SIZE+2, RD_GAP).
REQ-027 SHALL hold rd_data until the next cmd=11 frame completes.
REQ-028 SHALL, with RD_GAP=0, go from SEND directly to RECV.

Reset
REQ-029 SHALL, on rst_n=0, immediately set: state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, counter=0, shift registers=0.
REQ-030 SHALL abort a frame if reset occurs mid-frame, with no done and no rd_valid; after release the block is in IDLE, ready for start.

Configuration
REQ-031 SHALL, with SPI_MASTER_SEQ_CHECK_EN defined, add output err (1 bit, reset 0) and track the last accepted command.
REQ-032 SHALL, with the macro defined, reject cmd 01 not preceded by 00 and cmd 11 not preceded by 10: no frame is sent, SS_n stays 1, busy stays 0, err pulses 1 cycle, and the tracked command is unchanged.
REQ-033 SHALL, without the macro, have no err port and accept every cmd in any order.

Structure
REQ-034 SHALL place the cmd encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the state enumeration in shared package spi_pkg, which the existing slave may also use.
REQ-035 SHALL keep the FSM, counter and both shift registers in the single module; no sub-module is needed.

Verification
REQ-036 SHALL check: start, cmd=00, data_in=8'hA5 -> MOSI sequence 0,0,0,1,0,1,0,0,1,0,1, SS_n low for 11 cycles, done at N+12.
REQ-037 SHALL check: cmd=10 data_in=8'h3C, then cmd=11 data_in=8'h00 with MISO driven 8'hC3 after RD_GAP -> rd_data=8'hC3, rd_valid and done together at N+22.
REQ-038 SHALL check: start held high for 30 cycles -> one frame per accept, SS_n high for exactly 1 cycle between frames, no frame corruption.
REQ-039 SHALL check: rst_n pulsed low during the 5th SEND bit -> SS_n=1 at once, no done, next start produces a full correct frame.
REQ-040 SHALL check: with SPI_MASTER_SEQ_CHECK_EN defined and reset followed by cmd=11 -> err pulse, SS_n stays 1; then cmd=10, cmd=11 -> normal frames.
REQ-041 SHALL check: RD_GAP=0 build, cmd=11 -> first MISO sample on the cycle after the last MOSI bit, rd_data correct.
